// File: rtl/serv_immseq.sv
// Sequencer for the bit-serial immediate decoder: classifies one instruction word,
// runs the 32-cycle shift window and holds a done flag until the core acknowledges it.
module serv_immseq #(
  parameter bit WITH_CSR = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ibus_ack,
  input  logic [31:0] i_ibus_rdt,
  output logic        o_ready,
  output logic        o_wb_en,
  output logic [24:0] o_wb_rdt,
  output logic        o_cnt_en,
  output logic        o_cnt_done,
  output logic [4:0]  o_cnt,
  output logic [3:0]  o_immdec_en,
  output logic [3:0]  o_ctrl,
  output logic        o_csr_imm_en,
  output logic        o_illegal,
  output logic        o_done,
  input  logic        i_done_ack
);

  // Handshake: a word is taken only when i_ibus_ack and o_ready are both high in the
  // same cycle; o_done stays high until the cycle i_done_ack is seen, and any ack
  // arriving while the sequencer is busy is discarded.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [3:0]  en_r, ctrl_r;
  logic        csr_r, ill_r;
  logic [4:0]  opcode;
  logic [3:0]  dec_en, dec_ctrl;
  logic        dec_csr, dec_ill;
  logic        accept;

  assign opcode = i_ibus_rdt[6:2];
  assign accept = i_ibus_ack && (state == S_IDLE);

  always_comb begin
    dec_en   = 4'b0000;
    dec_ctrl = 4'b0000;
    dec_csr  = 1'b0;
    dec_ill  = 1'b0;
    if (i_ibus_rdt[1:0] != 2'b11) begin
      dec_ill = 1'b1;
    end else begin
      case (opcode)
        5'b00000, 5'b00100, 5'b11001: begin dec_en = 4'b1100; dec_ctrl = 4'b1010; end
        5'b01000:                     begin dec_en = 4'b1001; dec_ctrl = 4'b0011; end
        5'b11000:                     begin dec_en = 4'b1001; dec_ctrl = 4'b0101; end
        5'b01101, 5'b00101:           begin dec_en = 4'b1110; dec_ctrl = 4'b0000; end
        5'b11011:                     begin dec_en = 4'b1110; dec_ctrl = 4'b1000; end
        5'b01100, 5'b00011:           begin dec_en = 4'b0000; dec_ctrl = 4'b0000; end
        5'b11100: begin
          // funct3[2] selects the CSR immediate forms; the others carry no immediate
          if (i_ibus_rdt[14]) begin
            if (WITH_CSR) begin
              dec_en  = 4'b0010;
              dec_csr = 1'b1;
            end else begin
              dec_ill = 1'b1;
            end
          end
        end
        default: dec_ill = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (i_ibus_ack) state_nxt = dec_ill ? S_DONE : S_RUN;
      S_RUN:  if (cnt == 5'd31) state_nxt = S_DONE;
      S_DONE: if (i_done_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= S_IDLE;
      cnt    <= 5'd0;
      en_r   <= 4'b0000;
      ctrl_r <= 4'b0000;
      csr_r  <= 1'b0;
      ill_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        en_r   <= dec_en;
        ctrl_r <= dec_ctrl;
        csr_r  <= dec_csr;
        ill_r  <= dec_ill;
      end else if ((state == S_DONE) && i_done_ack) begin
        en_r   <= 4'b0000;
        ctrl_r <= 4'b0000;
        csr_r  <= 1'b0;
        ill_r  <= 1'b0;
      end
      // Counter wraps 31 -> 0 on the last RUN cycle, so it is zero again in DONE
      if (state == S_RUN) cnt <= cnt + 5'd1;
    end
  end

  assign o_ready      = (state == S_IDLE);
  assign o_wb_en      = accept;
  assign o_wb_rdt     = i_ibus_rdt[31:7];
  assign o_cnt_en     = (state == S_RUN);
  assign o_cnt_done   = (state == S_RUN) && (cnt == 5'd31);
  assign o_cnt        = cnt;
  assign o_immdec_en  = en_r;
  assign o_ctrl       = ctrl_r;
  assign o_csr_imm_en = csr_r;
  assign o_illegal    = ill_r;
  assign o_done       = (state == S_DONE);

endmodule
